// File: rtl/collatz_pkg.sv
// Shared types and defaults for the Collatz engine family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package collatz_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/collatz_step.sv
// One Collatz iteration: x/2 for even x, 3x+1 for odd x, with overflow detect.
// Latency: purely combinational.
// Backpressure: none. Ports: x (current value) -> nx (next value), ovf (nx needs > WIDTH bits).
module collatz_step
  import collatz_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] nx,
  output logic             ovf
);

  // Two guard bits are enough: 3*(2**WIDTH-1)+1 < 2**(WIDTH+2).
  logic [WIDTH+1:0] wide;

  always_comb begin
    if (x[0]) begin
      wide = {2'b00, x} + {1'b0, x, 1'b0} + (WIDTH+2)'(1);
    end else begin
      wide = {3'b000, x[WIDTH-1:1]};
    end
  end

  assign ovf = |wide[WIDTH+1:WIDTH];
  assign nx  = wide[WIDTH-1:0];

endmodule

// File: rtl/collatz_engine.sv
// Collatz trajectory engine: one iteration per cycle (or per adv in step mode),
// tracking step count and peak, flagging overflow, zero start and step-limit timeout.
// Latency: k iterations to reach 1 -> done pulse k cycles after the start is captured.
// Backpressure: st ignored while busy; step_mode runs advance only on adv.
// Ports: clk/rst, st+co+step_mode start a run, adv steps it; x/steps/peak results,
//        bs busy, done one-cycle pulse, ovf/err_zero/tmo status flags.
module collatz_engine
  import collatz_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned MAX_STEPS = 2**CNT_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st,
  input  logic [WIDTH-1:0] co,
  input  logic             step_mode,
  input  logic             adv,
  output logic [WIDTH-1:0] x,
  output logic             bs,
  output logic             done,
  output logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] peak,
  output logic             ovf,
  output logic             err_zero,
  output logic             tmo
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

  state_e           state_q;
  logic [WIDTH-1:0] x_q, peak_q;
  logic [CNT_W-1:0] steps_q;
  logic             bs_q, done_q, ovf_q, err_zero_q, tmo_q, step_mode_q;

  logic [WIDTH-1:0] nx_d;
  logic [CNT_W-1:0] steps_d;
  logic             step_ovf;
  logic             iter_en;

  collatz_step #(.WIDTH(WIDTH)) u_step (
    .x   (x_q),
    .nx  (nx_d),
    .ovf (step_ovf)
  );

  assign steps_d = steps_q + CNT_W'(1);
  // Step mode is latched at start so toggling it mid-run cannot change pacing.
  assign iter_en = !step_mode_q || adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      peak_q      <= '0;
      steps_q     <= '0;
      bs_q        <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_zero_q  <= 1'b0;
      tmo_q       <= 1'b0;
      step_mode_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (st) begin
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            err_zero_q  <= 1'b0;
            steps_q     <= '0;
            step_mode_q <= step_mode;
            x_q         <= co;
            peak_q      <= co;
            if (co == '0) begin
              err_zero_q <= 1'b1;
              state_q    <= DONE;
              done_q     <= 1'b1;
            end else if (co == WIDTH'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              bs_q    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (iter_en) begin
            if (step_ovf) begin
              // x, steps and peak keep their pre-iteration values.
              ovf_q   <= 1'b1;
              state_q <= DONE;
              done_q  <= 1'b1;
              bs_q    <= 1'b0;
            end else begin
              x_q     <= nx_d;
              steps_q <= steps_d;
              if (nx_d > peak_q) peak_q <= nx_d;
              if (nx_d == WIDTH'(1)) begin
                state_q <= DONE;
                done_q  <= 1'b1;
                bs_q    <= 1'b0;
              end else if (steps_d == MAX_CNT) begin
                tmo_q   <= 1'b1;
                state_q <= DONE;
                done_q  <= 1'b1;
                bs_q    <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          bs_q    <= 1'b0;
        end
      endcase
    end
  end

  assign x        = x_q;
  assign bs       = bs_q;
  assign done     = done_q;
  assign steps    = steps_q;
  assign peak     = peak_q;
  assign ovf      = ovf_q;
  assign err_zero = err_zero_q;
  assign tmo      = tmo_q;

endmodule

// File: tb/tb_collatz_engine.sv
// Bench for collatz_engine: three instances (16-bit, 8-bit, 5-step limit) share stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_collatz_engine;

  logic        clk = 1'b0;
  logic        rst, st, step_mode, adv;
  logic [15:0] co;

  logic [15:0] x_o[3], steps_o[3], peak_o[3];
  logic        bs_o[3], done_o[3], ovf_o[3], ez_o[3], tmo_o[3];
  logic [7:0]  x8, peak8;

  int          w_of[3]    = '{16, 8, 16};
  longint      maxs_of[3] = '{65535, 65535, 5};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  collatz_engine u_dut16 (
    .clk(clk), .rst(rst), .st(st), .co(co), .step_mode(step_mode), .adv(adv),
    .x(x_o[0]), .bs(bs_o[0]), .done(done_o[0]), .steps(steps_o[0]), .peak(peak_o[0]),
    .ovf(ovf_o[0]), .err_zero(ez_o[0]), .tmo(tmo_o[0])
  );

  collatz_engine #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .st(st), .co(co[7:0]), .step_mode(step_mode), .adv(adv),
    .x(x8), .bs(bs_o[1]), .done(done_o[1]), .steps(steps_o[1]), .peak(peak8),
    .ovf(ovf_o[1]), .err_zero(ez_o[1]), .tmo(tmo_o[1])
  );
  assign x_o[1]    = {8'b0, x8};
  assign peak_o[1] = {8'b0, peak8};

  collatz_engine #(.MAX_STEPS(5)) u_dutm (
    .clk(clk), .rst(rst), .st(st), .co(co), .step_mode(step_mode), .adv(adv),
    .x(x_o[2]), .bs(bs_o[2]), .done(done_o[2]), .steps(steps_o[2]), .peak(peak_o[2]),
    .ovf(ovf_o[2]), .err_zero(ez_o[2]), .tmo(tmo_o[2])
  );

  task automatic check(input string tag, input longint unsigned got, input longint unsigned want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference: walk the trajectory with plain integer arithmetic.
  task automatic model(input longint unsigned c, input int w, input longint unsigned maxs,
                       output longint unsigned ex, output longint unsigned es,
                       output longint unsigned ep, output bit eo, output bit et,
                       output bit ez, output int ecyc);
    longint unsigned lim;
    longint unsigned nx;
    lim = 64'd1 << w;
    ex = c; ep = c; es = 0; eo = 0; et = 0; ez = (c == 0); ecyc = 0;
    if (c < 2) return;
    forever begin
      nx = (ex % 2 == 0) ? ex / 2 : 3 * ex + 1;
      if (nx >= lim) begin
        eo = 1; ecyc = int'(es) + 1;
        return;
      end
      ex = nx; es++;
      if (nx > ep) ep = nx;
      if (ex == 1 || es == maxs) begin
        et = (ex != 1); ecyc = int'(es);
        return;
      end
    end
  endtask

  // Leaves the bench at the negedge just after the capture edge.
  task automatic start(input logic [15:0] v, input logic sm);
    @(negedge clk);
    co = v; step_mode = sm; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s.d%0d.x", tag, d), x_o[d], 0);
      check($sformatf("%s.d%0d.bs", tag, d), bs_o[d], 0);
      check($sformatf("%s.d%0d.done", tag, d), done_o[d], 0);
      check($sformatf("%s.d%0d.steps", tag, d), steps_o[d], 0);
      check($sformatf("%s.d%0d.peak", tag, d), peak_o[d], 0);
      check($sformatf("%s.d%0d.flags", tag, d), {ovf_o[d], ez_o[d], tmo_o[d]}, 0);
    end
  endtask

  task automatic run_check(input logic [15:0] v, input string tag);
    longint unsigned ex[3], es[3], ep[3];
    bit eo[3], et[3], ez[3];
    int ecyc[3], cyc[3], npulse[3], bs_bad[3];
    int c, last;
    bit all_seen;
    for (int d = 0; d < 3; d++) begin
      longint unsigned a, b, p;
      bit o, t, z;
      int k;
      model((d == 1) ? longint'(v[7:0]) : longint'(v), w_of[d], maxs_of[d], a, b, p, o, t, z, k);
      ex[d] = a; es[d] = b; ep[d] = p; eo[d] = o; et[d] = t; ez[d] = z; ecyc[d] = k;
      cyc[d] = -1; npulse[d] = 0; bs_bad[d] = 0;
    end
    start(v, 1'b0);
    c = 0;
    while (c < 1200) begin
      all_seen = 1'b1; last = 0;
      for (int d = 0; d < 3; d++) begin
        if (done_o[d]) npulse[d]++;
        if (done_o[d] && cyc[d] < 0) cyc[d] = c;
        if (bs_o[d] !== (c < ecyc[d])) bs_bad[d]++;
        if (cyc[d] < 0) all_seen = 1'b0;
        else if (cyc[d] > last) last = cyc[d];
      end
      if (all_seen && c >= last + 2) break;
      @(negedge clk);
      c++;
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s.d%0d.latency", tag, d), longint'(cyc[d]), longint'(ecyc[d]));
      check($sformatf("%s.d%0d.pulses", tag, d), npulse[d], 1);
      check($sformatf("%s.d%0d.bs_bad", tag, d), bs_bad[d], 0);
      check($sformatf("%s.d%0d.x", tag, d), x_o[d], ex[d]);
      check($sformatf("%s.d%0d.steps", tag, d), steps_o[d], es[d]);
      check($sformatf("%s.d%0d.peak", tag, d), peak_o[d], ep[d]);
      check($sformatf("%s.d%0d.ovf", tag, d), ovf_o[d], eo[d]);
      check($sformatf("%s.d%0d.tmo", tag, d), tmo_o[d], et[d]);
      check($sformatf("%s.d%0d.ez", tag, d), ez_o[d], ez[d]);
    end
  endtask

  initial begin
    int seq[9] = '{6, 3, 10, 5, 16, 8, 4, 2, 1};
    int idx;
    logic [15:0] v;

    rst = 1'b1; st = 1'b0; co = '0; step_mode = 1'b0; adv = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // co=6 free-running: one value per cycle.
    start(16'd6, 1'b0);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("seq6.x%0d", i), x_o[0], seq[i]);
      check($sformatf("seq6.done%0d", i), done_o[0], (i == 8));
      if (i < 8) @(negedge clk);
    end
    check("seq6.steps", steps_o[0], 8);
    check("seq6.peak", peak_o[0], 16);
    @(negedge clk);
    check("seq6.done_after", done_o[0], 0);
    check("seq6.bs_after", bs_o[0], 0);

    run_check(16'd27, "c27");
    check("c27.w16.steps", steps_o[0], 111);
    check("c27.w16.peak", peak_o[0], 9232);
    check("c27.w16.x", x_o[0], 1);
    check("c27.w8.x", x_o[1], 107);
    check("c27.w8.steps", steps_o[1], 11);
    check("c27.w8.peak", peak_o[1], 214);
    check("c27.w8.ovf", ovf_o[1], 1);

    run_check(16'd7, "c7");
    check("c7.m5.x", x_o[2], 52);
    check("c7.m5.steps", steps_o[2], 5);
    check("c7.m5.tmo", tmo_o[2], 1);

    run_check(16'd0, "c0");
    check("c0.ez", ez_o[0], 1);
    run_check(16'd1, "c1");
    check("c1.x", x_o[0], 1);
    run_check(16'd2, "c2");
    run_check(16'hFFFF, "cmax");

    // Step mode: adv every third cycle, x must hold in between.
    start(16'd6, 1'b1);
    idx = 0;
    for (int i = 0; i < 60 && idx < 8; i++) begin
      check("step.x", x_o[0], seq[idx]);
      check("step.bs", bs_o[0], 1);
      adv = (i % 3 == 2);
      @(negedge clk);
      if (adv) idx++;
    end
    adv = 1'b0;
    check("step.idx", idx, 8);
    check("step.x_end", x_o[0], 1);
    check("step.done", done_o[0], 1);
    check("step.steps", steps_o[0], 8);

    // st during RUN is ignored: 27 -> 82 -> 41 -> 124 -> 62 -> 31 ...
    start(16'd27, 1'b0);
    repeat (4) @(negedge clk);
    check("midst.x_before", x_o[0], 62);
    co = 16'd100; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    check("midst.x", x_o[0], 31);
    check("midst.steps", steps_o[0], 5);
    check("midst.bs", bs_o[0], 1);
    @(negedge clk);
    check("midst.x_next", x_o[0], 94);

    // rst mid-run returns everything to zero on the next cycle.
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      v = (i % 4 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      run_check(v, $sformatf("rnd%0d_%0d", i, v));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
